// File: rtl/axis_dst_port_demux.sv
// AXIS destination-port demux: routes each packet to the queues named in its first-beat tuser bitmap.
// Optional DEMUX_NO_HAIRPIN_EN masks the source port out of the destination bitmap.
module axis_dst_port_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS       = 16,
    parameter int DST_PORT_POS       = 24,
    parameter int NUM_OUTPUT_QUEUES  = 8
) (
    input  logic                               axi_aclk,
    input  logic                               axi_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                               m_axis_tlast,
    output logic [NUM_OUTPUT_QUEUES-1:0]       m_axis_tvalid,
    input  logic [NUM_OUTPUT_QUEUES-1:0]       m_axis_tready,
    input  logic                               rst_cntrs,
    output logic [31:0]                        pkt_fwd_cntr,
    output logic [31:0]                        pkt_drop_cntr
);

    localparam int NQ = NUM_OUTPUT_QUEUES;

    if (NQ > 8 || NQ < 1 ||
        SRC_PORT_POS + NQ > C_AXIS_TUSER_WIDTH ||
        DST_PORT_POS + NQ > C_AXIS_TUSER_WIDTH) begin : g_param_check
        $error("axis_dst_port_demux: bad queue count or bitmap position");
    end

    typedef enum logic [1:0] {SOP, FWD, DROP} state_t;

    state_t          state, state_nxt;
    logic [NQ-1:0]   pending, dst_mask, pkt_mask, load_mask;
    logic            accept, load, fwd_done, drop_done;
    logic [31:0]     fwd_cnt, drop_cnt;

`ifdef DEMUX_NO_HAIRPIN_EN
    assign pkt_mask = s_axis_tuser[DST_PORT_POS +: NQ] & ~s_axis_tuser[SRC_PORT_POS +: NQ];
`else
    assign pkt_mask = s_axis_tuser[DST_PORT_POS +: NQ];
`endif

    // A new beat may enter only once every queue still owed the current beat takes it now.
    assign s_axis_tready = (state == DROP) || ((pending & ~m_axis_tready) == '0);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load_mask     = (state == SOP) ? pkt_mask : dst_mask;
    assign m_axis_tvalid = pending;
    assign pkt_fwd_cntr  = fwd_cnt;
    assign pkt_drop_cntr = drop_cnt;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fwd_done  = 1'b0;
        drop_done = 1'b0;
        case (state)
            SOP: if (accept) begin
                if (|pkt_mask) begin
                    load = 1'b1;
                    if (s_axis_tlast) fwd_done = 1'b1;
                    else              state_nxt = FWD;
                end else begin
                    if (s_axis_tlast) drop_done = 1'b1;
                    else              state_nxt = DROP;
                end
            end
            FWD: if (accept) begin
                load = 1'b1;
                if (s_axis_tlast) begin
                    fwd_done  = 1'b1;
                    state_nxt = SOP;
                end
            end
            DROP: if (accept && s_axis_tlast) begin
                drop_done = 1'b1;
                state_nxt = SOP;
            end
            default: state_nxt = SOP;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state        <= SOP;
            pending      <= '0;
            dst_mask     <= '0;
            m_axis_tdata <= '0;
            m_axis_tstrb <= '0;
            m_axis_tuser <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SOP && accept) dst_mask <= pkt_mask;
            if (load) begin
                pending      <= load_mask;
                m_axis_tdata <= s_axis_tdata;
                m_axis_tstrb <= s_axis_tstrb;
                m_axis_tuser <= s_axis_tuser;
                m_axis_tlast <= s_axis_tlast;
            end else begin
                pending <= pending & ~m_axis_tready;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || rst_cntrs) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (fwd_done)  fwd_cnt  <= fwd_cnt + 32'd1;
            if (drop_done) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_dst_port_demux.sv
// Directed, table-driven bench for axis_dst_port_demux; expectations follow DEMUX_NO_HAIRPIN_EN.
module tb_axis_dst_port_demux;

`ifdef DEMUX_NO_HAIRPIN_EN
    localparam bit HP = 1'b1;
`else
    localparam bit HP = 1'b0;
`endif

    logic         axi_aclk = 1'b0;
    logic         axi_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tlast;
    logic [7:0]   m_axis_tvalid, m_axis_tready;
    logic         rst_cntrs;
    logic [31:0]  pkt_fwd_cntr, pkt_drop_cntr;

    int checks = 0;
    int errors = 0;

    axis_dst_port_demux dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .rst_cntrs(rst_cntrs), .pkt_fwd_cntr(pkt_fwd_cntr), .pkt_drop_cntr(pkt_drop_cntr)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic       v;
        logic [7:0] d, dst, src;
        logic       l;
        logic [7:0] rdy;
        logic       erdy;
        logic [7:0] evld, ed;
        logic       el;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(logic v, logic [7:0] d, logic [7:0] dst, logic [7:0] src,
                                 logic l, logic [7:0] rdy, logic erdy, logic [7:0] evld,
                                 logic [7:0] ed, logic el);
        vec_t r;
        r.v = v; r.d = d; r.dst = dst; r.src = src; r.l = l; r.rdy = rdy;
        r.erdy = erdy; r.evld = evld; r.ed = ed; r.el = el;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] d, logic [7:0] dst, logic [7:0] src,
                         logic l, logic [7:0] rdy);
        logic [127:0] u;
        u = '0;
        u[24 +: 8] = dst;
        u[16 +: 8] = src;
        s_axis_tvalid = v;
        s_axis_tdata  = {248'd0, d};
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
    endtask

    initial begin
        axi_reset = 1'b1; rst_cntrs = 1'b0; s_axis_tstrb = '1;
        drive(0, 0, 0, 0, 0, 8'h00);

        // 3-beat packet to queue 2, all ready
        vecs.push_back(row(1, 8'h01, 8'h04, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h02, 8'h04, 0, 0, 8'hFF, 1, 8'h04, 8'h01, 0));
        vecs.push_back(row(1, 8'h03, 8'h04, 0, 1, 8'hFF, 1, 8'h04, 8'h02, 0));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h04, 8'h03, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        // 2-beat multicast 0x05, queue 2 late by 3 cycles per beat
        vecs.push_back(row(1, 8'h11, 8'h05, 0, 0, 8'h01, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h12, 8'h05, 0, 1, 8'h01, 0, 8'h05, 8'h11, 0));
        vecs.push_back(row(1, 8'h12, 8'h05, 0, 1, 8'h01, 0, 8'h04, 8'h11, 0));
        vecs.push_back(row(1, 8'h12, 8'h05, 0, 1, 8'h01, 0, 8'h04, 8'h11, 0));
        vecs.push_back(row(1, 8'h12, 8'h05, 0, 1, 8'h05, 1, 8'h04, 8'h11, 0));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'h01, 0, 8'h05, 8'h12, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'h01, 0, 8'h04, 8'h12, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'h01, 0, 8'h04, 8'h12, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'h05, 1, 8'h04, 8'h12, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        // 4-beat drop, no queue ready, later-beat tuser ignored
        vecs.push_back(row(1, 8'h20, 8'h00, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h21, 8'hFF, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h22, 8'hFF, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h23, 8'hFF, 0, 1, 8'h00, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        // back-to-back, tuser changes mid-packet 1
        vecs.push_back(row(1, 8'h21, 8'h01, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 8'h22, 8'h02, 0, 1, 8'hFF, 1, 8'h01, 8'h21, 0));
        vecs.push_back(row(1, 8'h31, 8'h02, 0, 1, 8'hFF, 1, 8'h01, 8'h22, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h02, 8'h31, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));
        // hairpin: src=dst=0x02, then src=0x02 dst=0x03
        vecs.push_back(row(1, 8'h41, 8'h02, 8'h02, 1, 8'hFF, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, HP ? 8'h00 : 8'h02, HP ? 8'h00 : 8'h41, !HP));
        vecs.push_back(row(1, 8'h42, 8'h03, 8'h02, 1, 8'hFF, 1, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, HP ? 8'h01 : 8'h03, 8'h42, 1));
        vecs.push_back(row(0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 8'h00, 8'h00, 0));

        // reset state
        repeat (3) @(negedge axi_aclk);
        chk("rst_tvalid", {24'd0, m_axis_tvalid}, 0);
        chk("rst_tdata", m_axis_tdata[31:0], 0);
        chk("rst_tuser", m_axis_tuser[31:0], 0);
        chk("rst_tlast", {31'd0, m_axis_tlast}, 0);
        chk("rst_fwd", pkt_fwd_cntr, 0);
        chk("rst_drop", pkt_drop_cntr, 0);
        axi_reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].dst, vecs[i].src, vecs[i].l, vecs[i].rdy);
            #1;
            chk($sformatf("row%0d_tready", i), {31'd0, s_axis_tready}, {31'd0, vecs[i].erdy});
            chk($sformatf("row%0d_tvalid", i), {24'd0, m_axis_tvalid}, {24'd0, vecs[i].evld});
            if (vecs[i].evld != 8'h00) begin
                chk($sformatf("row%0d_tdata", i), m_axis_tdata[31:0], {24'd0, vecs[i].ed});
                chk($sformatf("row%0d_tlast", i), {31'd0, m_axis_tlast}, {31'd0, vecs[i].el});
            end
            @(negedge axi_aclk);
        end
        chk("tbl_fwd", pkt_fwd_cntr, HP ? 32'd5 : 32'd6);
        chk("tbl_drop", pkt_drop_cntr, HP ? 32'd2 : 32'd1);

        // reset mid-packet, then 1-beat packet to queue 3
        drive(1, 8'h51, 8'h01, 0, 0, 8'h00);
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 0, 8'h00);
        axi_reset = 1'b1;
        @(negedge axi_aclk);
        axi_reset = 1'b0;
        chk("mid_rst_tvalid", {24'd0, m_axis_tvalid}, 0);
        chk("mid_rst_fwd", pkt_fwd_cntr, 0);
        chk("mid_rst_drop", pkt_drop_cntr, 0);
        drive(1, 8'h52, 8'h08, 0, 1, 8'hFF);
        #1 chk("mid_rst_tready", {31'd0, s_axis_tready}, 1);
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 0, 8'hFF);
        chk("post_rst_tvalid", {24'd0, m_axis_tvalid}, 32'h08);
        chk("post_rst_tdata", m_axis_tdata[31:0], 32'h52);
        chk("post_rst_tuser", {24'd0, m_axis_tuser[31:24]}, 32'h08);
        chk("post_rst_tstrb", m_axis_tstrb, 32'hFFFF_FFFF);
        chk("post_rst_tlast", {31'd0, m_axis_tlast}, 1);
        chk("post_rst_fwd", pkt_fwd_cntr, 1);

        // clear beats a same-cycle increment at the wrap point
        force dut.fwd_cnt = 32'hFFFF_FFFF;
        #1 release dut.fwd_cnt;
        #1 chk("preset_fwd", pkt_fwd_cntr, 32'hFFFF_FFFF);
        drive(1, 8'h61, 8'h01, 0, 1, 8'hFF);
        rst_cntrs = 1'b1;
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 0, 8'hFF);
        rst_cntrs = 1'b0;
        chk("clr_prio_fwd", pkt_fwd_cntr, 0);

        // plain wrap of both counters
        force dut.fwd_cnt = 32'hFFFF_FFFF;
        force dut.drop_cnt = 32'hFFFF_FFFF;
        #1 begin release dut.fwd_cnt; release dut.drop_cnt; end
        drive(1, 8'h71, 8'h01, 0, 1, 8'hFF);
        @(negedge axi_aclk);
        drive(1, 8'h72, 8'h00, 0, 1, 8'hFF);
        chk("wrap_fwd", pkt_fwd_cntr, 0);
        chk("wrap_drop_hold", pkt_drop_cntr, 32'hFFFF_FFFF);
        @(negedge axi_aclk);
        drive(0, 0, 0, 0, 0, 8'hFF);
        chk("wrap_drop", pkt_drop_cntr, 0);
        chk("wrap_fwd_hold", pkt_fwd_cntr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
